// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared widths, reset PC, NOP encoding and fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int          REG_W               = 32;
  localparam logic [31:0] LOONG_PC_START_ADDR = 32'h1c00_0000;
  localparam logic [31:0] LOONG_NOP_INST      = 32'h0340_0000;
  // Packed {adef, pc, inst} bus towards decode.
  localparam int          IF2ID_BUS_W         = REG_W + 33;

  typedef enum logic [1:0] {
    IF_ST_IDLE = 2'd0,
    IF_ST_REQ  = 2'd1,
    IF_ST_WAIT = 2'd2,
    IF_ST_HOLD = 2'd3
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage: one outstanding SRAM-like request,
//               buffers the returned word and hands it to decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter int          REG_W_P  = REG_W,
  parameter logic [31:0] NOP_INST = LOONG_NOP_INST
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [REG_W_P-1:0] if_pc_i,
  input  logic [32:0]        jbr_bus_i,
  output logic               pc_stall_o,
  output logic               inst_req_o,
  output logic [REG_W_P-1:0] inst_addr_o,
  input  logic               inst_addr_ok_i,
  input  logic               inst_data_ok_i,
  input  logic [31:0]        inst_rdata_i,
  input  logic               id_ready_i,
  output logic               if_valid_o,
  output logic [REG_W_P-1:0] if_pc_o,
  output logic [31:0]        if_inst_o,
  output logic               if_adef_o
);

  if_state_e          state_q, state_d;
  logic               cancel_q, cancel_d;
  logic [REG_W_P-1:0] pc_buf_q, pc_buf_d;
  logic [31:0]        inst_buf_q, inst_buf_d;
  logic               adef_buf_q, adef_buf_d;

  logic jbr_taken;
  logic misaligned;
  logic accept;
  logic unused_jbr_target;

  assign jbr_taken         = jbr_bus_i[32];
  assign unused_jbr_target = ^jbr_bus_i[31:0];
  assign misaligned        = |if_pc_i[1:0];

  assign inst_addr_o = if_pc_i;
  assign inst_req_o  = ~rst_i & (state_q == IF_ST_REQ) & ~misaligned;
  assign accept      = inst_req_o & inst_addr_ok_i;
  // The PC moves exactly when a fetch is issued (or skipped as ADEF) or on a jump.
  assign pc_stall_o  = rst_i | ~(jbr_taken | accept | ((state_q == IF_ST_REQ) & misaligned));

  assign if_valid_o = ~rst_i & (state_q == IF_ST_HOLD) & ~jbr_taken;
  assign if_pc_o    = pc_buf_q;
  assign if_inst_o  = inst_buf_q;
  assign if_adef_o  = adef_buf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IF_ST_IDLE;
      cancel_q   <= 1'b0;
      pc_buf_q   <= '0;
      inst_buf_q <= '0;
      adef_buf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cancel_q   <= cancel_d;
      pc_buf_q   <= pc_buf_d;
      inst_buf_q <= inst_buf_d;
      adef_buf_q <= adef_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    pc_buf_d   = pc_buf_q;
    inst_buf_d = inst_buf_q;
    adef_buf_d = adef_buf_q;
    case (state_q)
      IF_ST_IDLE: state_d = IF_ST_REQ;
      IF_ST_REQ: begin
        if (jbr_taken) begin
          // An accepted wrong-path request must still be drained.
          if (accept) begin
            pc_buf_d = if_pc_i;
            cancel_d = 1'b1;
            state_d  = IF_ST_WAIT;
          end
        end else if (misaligned) begin
          pc_buf_d   = if_pc_i;
          inst_buf_d = NOP_INST;
          adef_buf_d = 1'b1;
          state_d    = IF_ST_HOLD;
        end else if (accept) begin
          pc_buf_d = if_pc_i;
          state_d  = IF_ST_WAIT;
        end
      end
      IF_ST_WAIT: begin
        if (inst_data_ok_i) begin
          if (cancel_q || jbr_taken) begin
            cancel_d = 1'b0;
            state_d  = IF_ST_REQ;
          end else begin
            inst_buf_d = inst_rdata_i;
            adef_buf_d = 1'b0;
            state_d    = IF_ST_HOLD;
          end
        end else if (jbr_taken) begin
          cancel_d = 1'b1;
        end
      end
      IF_ST_HOLD: begin
        if (jbr_taken || id_ready_i) state_d = IF_ST_REQ;
      end
      default: state_d = IF_ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage with a PC register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic [32:0] jbr_bus;
  logic        pc_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adef;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_pc_i        (pc_q),
    .jbr_bus_i      (jbr_bus),
    .pc_stall_o     (pc_stall),
    .inst_req_o     (inst_req),
    .inst_addr_o    (inst_addr),
    .inst_addr_ok_i (addr_ok),
    .inst_data_ok_i (data_ok),
    .inst_rdata_i   (rdata),
    .id_ready_i     (id_ready),
    .if_valid_o     (if_valid),
    .if_pc_o        (if_pc),
    .if_inst_o      (if_inst),
    .if_adef_o      (if_adef)
  );

  // PC register that sits next to the fetch stage.
  always @(posedge clk) begin
    if (rst)               pc_q <= 32'h1c00_0000;
    else if (jbr_bus[32])  pc_q <= jbr_bus[31:0];
    else if (!pc_stall)    pc_q <= pc_q + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    jbr_bus  = '0;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    id_ready = 1'b0;
    rdata    = '0;
  endtask

  initial begin
    rst = 1'b1;
    jbr_bus = '0; addr_ok = 1'b0; data_ok = 1'b0; id_ready = 1'b0; rdata = '0;
    nxt(); nxt();
    #1;
    chk("rst_req",   {31'd0, inst_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc",    if_pc,             32'd0);
    chk("rst_inst",  if_inst,           32'd0);
    chk("rst_adef",  {31'd0, if_adef},  32'd0);
    chk("rst_stall", {31'd0, pc_stall}, 32'd1);

    rst = 1'b0;
    #1;
    chk("idle_req",   {31'd0, inst_req}, 32'd0);
    chk("idle_stall", {31'd0, pc_stall}, 32'd1);

    // First fetch: addr_ok now, data_ok next cycle.
    nxt(); addr_ok = 1'b1; #1;
    chk("req1_req",   {31'd0, inst_req}, 32'd1);
    chk("req1_addr",  inst_addr,         32'h1c00_0000);
    chk("req1_stall", {31'd0, pc_stall}, 32'd0);
    nxt(); data_ok = 1'b1; rdata = 32'h0280_0421; #1;
    chk("wait1_req",   {31'd0, inst_req}, 32'd0);
    chk("wait1_valid", {31'd0, if_valid}, 32'd0);
    chk("wait1_stall", {31'd0, pc_stall}, 32'd1);

    // HOLD with decode backpressure for four cycles.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt(); else begin nxt(); end
      #1;
      chk("bp_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_pc",    if_pc,             32'h1c00_0000);
      chk("bp_inst",  if_inst,           32'h0280_0421);
      chk("bp_adef",  {31'd0, if_adef},  32'd0);
      chk("bp_stall", {31'd0, pc_stall}, 32'd1);
      chk("bp_req",   {31'd0, inst_req}, 32'd0);
    end
    id_ready = 1'b1; #1;
    chk("hs_valid", {31'd0, if_valid}, 32'd1);

    // Second fetch; jump while waiting for data.
    nxt(); addr_ok = 1'b1; #1;
    chk("req2_req",  {31'd0, inst_req}, 32'd1);
    chk("req2_addr", inst_addr,         32'h1c00_0004);
    nxt(); jbr_bus = {1'b1, 32'h1c00_0100}; #1;
    chk("wjbr_stall", {31'd0, pc_stall}, 32'd0);
    chk("wjbr_valid", {31'd0, if_valid}, 32'd0);
    nxt(); #1;
    chk("wc_valid", {31'd0, if_valid}, 32'd0);
    chk("wc_req",   {31'd0, inst_req}, 32'd0);
    nxt(); data_ok = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    nxt(); jbr_bus = {1'b1, 32'h1c00_0008}; #1;
    chk("req3_valid", {31'd0, if_valid}, 32'd0);
    chk("req3_req",   {31'd0, inst_req}, 32'd1);
    chk("req3_addr",  inst_addr,         32'h1c00_0100);
    chk("req3_stall", {31'd0, pc_stall}, 32'd0);

    // Jump in the same cycle as addr_ok for 0x1c000008.
    nxt(); addr_ok = 1'b1; jbr_bus = {1'b1, 32'h1c00_0200}; #1;
    chk("acc_jbr_req",   {31'd0, inst_req}, 32'd1);
    chk("acc_jbr_addr",  inst_addr,         32'h1c00_0008);
    chk("acc_jbr_stall", {31'd0, pc_stall}, 32'd0);
    nxt(); data_ok = 1'b1; rdata = 32'h1111_1111; #1;
    chk("acc_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("acc_drop_stall", {31'd0, pc_stall}, 32'd1);
    nxt(); jbr_bus = {1'b1, 32'h1c00_0002}; #1;
    chk("tgt_valid", {31'd0, if_valid}, 32'd0);
    chk("tgt_req",   {31'd0, inst_req}, 32'd1);
    chk("tgt_addr",  inst_addr,         32'h1c00_0200);

    // Misaligned PC produces an ADEF NOP without a request.
    nxt(); addr_ok = 1'b1; #1;
    chk("mis_req",   {31'd0, inst_req}, 32'd0);
    chk("mis_stall", {31'd0, pc_stall}, 32'd0);
    nxt(); #1;
    chk("adef_valid", {31'd0, if_valid}, 32'd1);
    chk("adef_flag",  {31'd0, if_adef},  32'd1);
    chk("adef_inst",  if_inst,           32'h0340_0000);
    chk("adef_pc",    if_pc,             32'h1c00_0002);
    chk("adef_req",   {31'd0, inst_req}, 32'd0);
    // Flush in HOLD beats id_ready.
    jbr_bus = {1'b1, 32'h1c00_0300}; id_ready = 1'b1; #1;
    chk("hflush_valid", {31'd0, if_valid}, 32'd0);
    chk("hflush_stall", {31'd0, pc_stall}, 32'd0);
    nxt(); addr_ok = 1'b1; #1;
    chk("req4_req",  {31'd0, inst_req}, 32'd1);
    chk("req4_addr", inst_addr,         32'h1c00_0300);

    // Reset asserted while in WAIT, then a stale data_ok.
    nxt(); rst = 1'b1; #1;
    chk("mrst_req",   {31'd0, inst_req}, 32'd0);
    chk("mrst_stall", {31'd0, pc_stall}, 32'd1);
    nxt(); rst = 1'b0; data_ok = 1'b1; rdata = 32'h2222_2222; #1;
    chk("prst_valid", {31'd0, if_valid}, 32'd0);
    chk("prst_req",   {31'd0, inst_req}, 32'd0);
    chk("prst_stall", {31'd0, pc_stall}, 32'd1);
    chk("prst_pc",    if_pc,             32'd0);
    chk("prst_inst",  if_inst,           32'd0);
    nxt(); #1;
    chk("stale_valid", {31'd0, if_valid}, 32'd0);
    chk("stale_req",   {31'd0, inst_req}, 32'd1);
    chk("stale_addr",  inst_addr,         32'h1c00_0000);
    chk("stale_pc",    if_pc,             32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
